// File: rtl/mul_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mul_add_arbiter
// Brief    : Round-robin 4-way arbiter sharing one multiply-add unit, with a
//            bounded wait for completion and abort on timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mul_add_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 64
) (
   input  logic                    clk,
   input  logic                    aclr,
   input  logic [3:0]              req,
   input  logic [4*DATA_WIDTH-1:0] req_dataa,
   input  logic [4*DATA_WIDTH-1:0] req_datab,
   output logic [3:0]              ack,
   output logic [DATA_WIDTH-1:0]   result,
   output logic                    err,
   output logic                    busy,
   output logic                    unit_en,
   output logic [DATA_WIDTH-1:0]   unit_dataa,
   output logic [DATA_WIDTH-1:0]   unit_datab,
   output logic                    unit_aclr,
   input  logic                    unit_done,
   input  logic [DATA_WIDTH-1:0]   unit_result
);

   localparam int               CNT_W      = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ISSUE   = 3'd1,
      S_WAIT    = 3'd2,
      S_RESPOND = 3'd3,
      S_ABORT   = 3'd4
   } state_t;

   state_t           r_state;
   logic [1:0]       r_owner;
   logic [1:0]       r_last_owner;
   logic [CNT_W-1:0] r_cnt;

   logic             w_grant_valid;
   logic [1:0]       w_grant_idx;
   logic [1:0]       w_cand;

   // Search starts just after the previous owner; the previous owner is tried last.
   always_comb begin
      w_grant_valid = 1'b0;
      w_grant_idx   = 2'd0;
      w_cand        = 2'd0;
      for (int k = 1; k <= 4; k++) begin
         w_cand = r_last_owner + 2'(k);
         if (!w_grant_valid && req[w_cand]) begin
            w_grant_valid = 1'b1;
            w_grant_idx   = w_cand;
         end
      end
   end

   assign unit_aclr = aclr | (r_state == S_ABORT);

   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         r_state      <= S_IDLE;
         r_owner      <= 2'd0;
         r_last_owner <= 2'd3;
         r_cnt        <= '0;
         ack          <= 4'd0;
         result       <= '0;
         err          <= 1'b0;
         busy         <= 1'b0;
         unit_en      <= 1'b0;
         unit_dataa   <= '0;
         unit_datab   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_grant_valid) begin
                  unit_dataa <= req_dataa[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];
                  unit_datab <= req_datab[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];
                  r_owner    <= w_grant_idx;
                  unit_en    <= 1'b1;
                  busy       <= 1'b1;
                  r_state    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               unit_en <= 1'b0;
               r_cnt   <= '0;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               // Completion wins over a coincident timeout.
               if (unit_done) begin
                  result  <= unit_result;
                  ack     <= 4'b0001 << r_owner;
                  err     <= 1'b0;
                  r_state <= S_RESPOND;
               end else if (r_cnt == C_CNT_LAST) begin
                  result  <= '0;
                  ack     <= 4'b0001 << r_owner;
                  err     <= 1'b1;
                  r_state <= S_ABORT;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_RESPOND, S_ABORT: begin
               ack          <= 4'd0;
               result       <= '0;
               err          <= 1'b0;
               busy         <= 1'b0;
               r_last_owner <= r_owner;
               r_state      <= S_IDLE;
            end
            default: begin
               ack     <= 4'd0;
               result  <= '0;
               err     <= 1'b0;
               busy    <= 1'b0;
               unit_en <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mul_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_add_arbiter
// Brief    : Self-checking bench for mul_add_arbiter with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_add_arbiter;

   localparam int DW = 32;
   localparam int TO = 64;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            aclr;
   logic [3:0]      req;
   logic [4*DW-1:0] req_dataa, req_datab;
   logic            unit_done;
   logic [DW-1:0]   unit_result;

   logic [3:0]      ack, ack4;
   logic [DW-1:0]   result, result4;
   logic            err, err4, busy, busy4, unit_en, unit_en4, unit_aclr, unit_aclr4;
   logic [DW-1:0]   unit_dataa, unit_datab, unit_dataa4, unit_datab4;

   mul_add_arbiter #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .aclr(aclr), .req(req), .req_dataa(req_dataa), .req_datab(req_datab),
      .ack(ack), .result(result), .err(err), .busy(busy), .unit_en(unit_en),
      .unit_dataa(unit_dataa), .unit_datab(unit_datab), .unit_aclr(unit_aclr),
      .unit_done(unit_done), .unit_result(unit_result)
   );

   mul_add_arbiter #(.DATA_WIDTH(DW), .TIMEOUT(4)) dut4 (
      .clk(clk), .aclr(aclr), .req(req), .req_dataa(req_dataa), .req_datab(req_datab),
      .ack(ack4), .result(result4), .err(err4), .busy(busy4), .unit_en(unit_en4),
      .unit_dataa(unit_dataa4), .unit_datab(unit_datab4), .unit_aclr(unit_aclr4),
      .unit_done(unit_done), .unit_result(unit_result)
   );

   int tests = 0;
   int fails = 0;
   int m_last;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Round-robin reference: first active requester after the last owner.
   function automatic int pick(input logic [3:0] r, input int last);
      for (int k = 1; k <= 4; k++)
         if (r[(last + k) % 4]) return (last + k) % 4;
      return -1;
   endfunction

   // d = cycle after unit_en in which done is pulsed (1..TO), 0 = never.
   task automatic run_op(input int d, input logic [DW-1:0] res, input bit disturb,
                         input bit stray, input bit chk4);
      int            win;
      int            n;
      bit            seen;
      logic [DW-1:0] ea, eb;
      logic [3:0]    eack;
      win = pick(req, m_last);
      if (win < 0) return;
      ea   = req_dataa[win*DW +: DW];
      eb   = req_datab[win*DW +: DW];
      eack = 4'b0001 << win;
      seen = 1'b0;
      for (int i = 0; i < 4 && !seen; i++) begin
         @(negedge clk);
         if (unit_en === 1'b1) seen = 1'b1;
         else chk("pre_grant_ack", ack, 0);
      end
      chk("grant_seen", seen, 1);
      chk("issue_busy", busy, 1);
      chk("issue_a", unit_dataa, ea);
      chk("issue_b", unit_datab, eb);
      if (disturb) begin
         req_dataa = {$urandom, $urandom, $urandom, $urandom};
         req_datab = {$urandom, $urandom, $urandom, $urandom};
         req[win]  = 1'b0;
      end
      n = (d == 0) ? TO : d;
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         chk("wait_en", unit_en, 0);
         chk("wait_ack", ack, 0);
         chk("wait_aclr", unit_aclr, 0);
         chk("wait_a", unit_dataa, ea);
         chk("wait_b", unit_datab, eb);
         if (k == d) begin
            unit_done   = 1'b1;
            unit_result = res;
         end
      end
      @(negedge clk);
      unit_done = 1'b0;
      chk("resp_ack", ack, eack);
      chk("resp_en", unit_en, 0);
      chk("resp_busy", busy, 1);
      if (d != 0) begin
         chk("resp_result", result, res);
         chk("resp_err", err, 0);
         chk("resp_aclr", unit_aclr, 0);
      end else begin
         chk("abort_result", result, 0);
         chk("abort_err", err, 1);
         chk("abort_aclr", unit_aclr, 1);
      end
      if (chk4) begin
         chk("t4_ack", ack4, eack);
         chk("t4_result", result4, res);
         chk("t4_err", err4, 0);
         chk("t4_aclr", unit_aclr4, 0);
      end
      m_last = win;
      if (stray) begin
         unit_done   = 1'b1;
         unit_result = $urandom;
      end
      @(negedge clk);
      unit_done = 1'b0;
      chk("idle_ack", ack, 0);
      chk("idle_busy", busy, 0);
      chk("idle_err", err, 0);
      chk("idle_result", result, 0);
      chk("idle_aclr", unit_aclr, 0);
   endtask

   task automatic do_reset();
      aclr = 1'b1;
      @(negedge clk);
      @(negedge clk);
      aclr   = 1'b0;
      m_last = 3;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      aclr        = 1'b1;
      req         = 4'd0;
      req_dataa   = '0;
      req_datab   = '0;
      unit_done   = 1'b0;
      unit_result = '0;
      m_last      = 3;
      #1;
      chk("rst_ack", ack, 0);
      chk("rst_result", result, 0);
      chk("rst_err", err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_en", unit_en, 0);
      chk("rst_a", unit_dataa, 0);
      chk("rst_b", unit_datab, 0);
      chk("rst_aclr", unit_aclr, 1);
      do_reset();
      @(negedge clk);
      chk("post_rst_aclr", unit_aclr, 0);
      chk("post_rst_busy", busy, 0);

      // Single directed multiply-add.
      req = 4'b0001;
      req_dataa[31:0] = 32'h4000_0000;
      req_datab[31:0] = 32'h4040_0000;
      run_op(12, 32'h4110_0000, 1'b0, 1'b0, 1'b0);
      req = 4'b0000;

      // All four requesting, each drops after its ack.
      do_reset();
      req       = 4'b1111;
      req_dataa = {$urandom, $urandom, $urandom, $urandom};
      req_datab = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < 4; i++) begin
         run_op($urandom_range(1, 20), $urandom, 1'b0, 1'b0, 1'b0);
         req[m_last] = 1'b0;
      end
      req = 4'b0101;
      for (int i = 0; i < 4; i++)
         run_op($urandom_range(1, 20), $urandom, 1'b0, (i == 1), 1'b0);
      req = 4'b0000;

      // Timeout on requester 1.
      req = 4'b0010;
      run_op(0, '0, 1'b0, 1'b0, 1'b0);
      req = 4'b0000;

      // Stray done while idle.
      unit_done   = 1'b1;
      unit_result = 32'hDEAD_BEEF;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stray_ack", ack, 0);
         chk("stray_busy", busy, 0);
         chk("stray_en", unit_en, 0);
      end
      unit_done = 1'b0;

      // Done in the last WAIT cycle of the short-timeout instance.
      do_reset();
      req = 4'b0001;
      run_op(4, $urandom, 1'b0, 1'b0, 1'b1);
      req = 4'b0000;

      // Reset in the middle of an operation owned by requester 2.
      do_reset();
      req  = 4'b0100;
      seen = 1'b0;
      for (int i = 0; i < 4 && !seen; i++) begin
         @(negedge clk);
         if (unit_en === 1'b1) seen = 1'b1;
      end
      chk("mid_grant_seen", seen, 1);
      repeat (5) @(negedge clk);
      aclr = 1'b1;
      req  = 4'b0000;
      #1;
      chk("mid_rst_ack", ack, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_en", unit_en, 0);
      chk("mid_rst_a", unit_dataa, 0);
      chk("mid_rst_b", unit_datab, 0);
      chk("mid_rst_aclr", unit_aclr, 1);
      @(negedge clk);
      aclr   = 1'b0;
      m_last = 3;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post_mid_ack", ack, 0);
         chk("post_mid_busy", busy, 0);
      end
      req = 4'b0101;
      run_op($urandom_range(1, 30), $urandom, 1'b0, 1'b0, 1'b0);
      req[m_last] = 1'b0;

      // Randomized traffic.
      for (int t = 0; t < 30; t++) begin
         if (req == 4'd0) req = 4'($urandom_range(1, 15));
         req_dataa = {$urandom, $urandom, $urandom, $urandom};
         req_datab = {$urandom, $urandom, $urandom, $urandom};
         run_op(($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TO)),
                $urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 1'b0);
         req[m_last] = 1'b0;
         req = req | 4'($urandom_range(0, 15));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
